// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the fetch/sequencing unit and the core control unit:
//   - RV32 major opcode values (instr[6:0])
//   - fetch FSM state encoding
//   - halt-cause codes reported on halt_cause
// ----------------------------------------------------------------------------
package rv_pkg;

    // Major opcodes accepted by the core
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // Halt causes
    localparam logic [1:0] HC_NONE     = 2'd0;
    localparam logic [1:0] HC_ILLEGAL  = 2'd1;
    localparam logic [1:0] HC_MISALIGN = 2'd2;

endpackage

// File: rtl/rv_fetch_seq_if.sv
// ----------------------------------------------------------------------------
// rv_fetch_seq_if
// Bundles the instruction-memory handshake, the instruction hand-off to the
// core and the halt status of the fetch sequencer.
//   master : the fetch sequencer (drives imem_req/addr, instr*, halt*)
//   slave  : memory + core side (drives imem_rvalid/rdata, instr_ready,
//            redirect_valid/target)
// Parameter PC_W must match the PC_W of the attached rv_fetch_seq.
// ----------------------------------------------------------------------------
interface rv_fetch_seq_if #(
    parameter int PC_W = 11
);
    // instruction memory
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    // instruction hand-off
    logic            instr_valid;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic [PC_W-1:0] link_pc;
    logic            instr_ready;
    // redirect from execute
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    // halt status
    logic            halt;
    logic [1:0]      halt_cause;
    logic [PC_W-1:0] halt_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, link_pc,
        input  instr_ready, redirect_valid, redirect_target,
        output halt, halt_cause, halt_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, link_pc,
        output instr_ready, redirect_valid, redirect_target,
        input  halt, halt_cause, halt_pc
    );
endinterface

// File: rtl/rv_fetch_seq_opcode_legal.sv
// ----------------------------------------------------------------------------
// rv_opcode_legal
// Purely combinational legality check of an RV32 major opcode.
//   opcode      in  7  instr[6:0]
//   allow_upper in  1  when 1, LUI and AUIPC are also legal
//   legal       out 1  opcode is executable by the core
// ----------------------------------------------------------------------------
module rv_opcode_legal
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       allow_upper,
    output logic       legal
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR: legal = 1'b1;
            OP_LUI, OP_AUIPC:                              legal = allow_upper;
            default:                                       legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_fetch_seq.sv
// ----------------------------------------------------------------------------
// rv_fetch_seq
// Fetch/sequencing unit: requests one instruction at a time from instruction
// memory, presents it to the core with its PC and link address, follows
// branch/jump redirects and halts on an illegal opcode or misaligned target.
//
// Parameters
//   PC_W        PC/address width; PC arithmetic wraps modulo 2^PC_W
//   RESET_PC    word-aligned PC loaded on reset
//   ALLOW_UPPER 1 makes LUI/AUIPC legal
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   bus         rv_fetch_seq_if.master (imem handshake, instr hand-off,
//               redirect, halt status)
//   perf_issued, perf_redirects (32 each) only when RV_FETCH_PERF_EN is
//               defined: accepted instructions / aligned redirects taken
//
// Build option: define RV_FETCH_PERF_EN to add the performance counters.
// ----------------------------------------------------------------------------
module rv_fetch_seq
    import rv_pkg::*;
#(
    parameter int              PC_W        = 11,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter bit              ALLOW_UPPER = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    rv_fetch_seq_if.master bus
`ifdef RV_FETCH_PERF_EN
    ,
    output logic [31:0]   perf_issued,
    output logic [31:0]   perf_redirects
`endif
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic [PC_W-1:0] link_pc_q, link_pc_d;
    logic [1:0]      halt_cause_q, halt_cause_d;
    logic [PC_W-1:0] halt_pc_q, halt_pc_d;

    logic opcode_ok;
    logic fetch_done;
    logic accept;
    logic redirect_ok;
    logic redirect_bad;

    rv_opcode_legal u_opcode_legal (
        .opcode      (bus.imem_rdata[6:0]),
        .allow_upper (ALLOW_UPPER),
        .legal       (opcode_ok)
    );

    // rvalid only counts while a request is outstanding
    assign fetch_done   = (state_q == ST_REQ) && bus.imem_rvalid;
    // redirect inputs only matter in the accept cycle
    assign accept       = (state_q == ST_ISSUE) && bus.instr_ready;
    assign redirect_ok  = accept && bus.redirect_valid && (bus.redirect_target[1:0] == 2'b00);
    assign redirect_bad = accept && bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) state_q <= ST_REQ;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (bus.imem_rvalid) state_d = opcode_ok ? ST_ISSUE : ST_HALT;
            end
            ST_ISSUE: begin
                if (bus.instr_ready) state_d = redirect_bad ? ST_HALT : ST_REQ;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_HALT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        bus.halt        = 1'b0;
        case (state_q)
            // request is masked while rst is held, since state_q already
            // reads ST_REQ during reset
            ST_REQ:   bus.imem_req    = !rst;
            ST_ISSUE: bus.instr_valid = 1'b1;
            ST_HALT:  bus.halt        = 1'b1;
            default:  bus.halt        = 1'b1;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        link_pc_d    = link_pc_q;
        halt_cause_d = halt_cause_q;
        halt_pc_d    = halt_pc_q;

        if (fetch_done) begin
            if (opcode_ok) begin
                instr_d    = bus.imem_rdata;
                instr_pc_d = pc_q;
                link_pc_d  = pc_q + PC_STEP;
            end else begin
                halt_cause_d = HC_ILLEGAL;
                halt_pc_d    = pc_q;
            end
        end

        if (accept) begin
            if (redirect_bad) begin
                halt_cause_d = HC_MISALIGN;
                halt_pc_d    = instr_pc_q;
            end else if (redirect_ok) begin
                pc_d = bus.redirect_target;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            link_pc_q    <= '0;
            halt_cause_q <= HC_NONE;
            halt_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            link_pc_q    <= link_pc_d;
            halt_cause_q <= halt_cause_d;
            halt_pc_q    <= halt_pc_d;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.instr      = instr_q;
    assign bus.instr_pc   = instr_pc_q;
    assign bus.link_pc    = link_pc_q;
    assign bus.halt_cause = halt_cause_q;
    assign bus.halt_pc    = halt_pc_q;

`ifdef RV_FETCH_PERF_EN
    // Counters advance only on accept, which never happens in HALT, so they
    // freeze there without extra gating.
    logic [31:0] perf_issued_q;
    logic [31:0] perf_redirects_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q    <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (accept)      perf_issued_q    <= perf_issued_q + 32'd1;
            if (redirect_ok) perf_redirects_q <= perf_redirects_q + 32'd1;
        end
    end

    assign perf_issued    = perf_issued_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_rv_fetch_seq.sv
// ----------------------------------------------------------------------------
// tb_rv_fetch_seq
// Directed bench for rv_fetch_seq. Two instances:
//   dut_a : PC_W=11, RESET_PC=0,    ALLOW_UPPER=0 (main sequencing, redirect,
//           stall, illegal and misaligned halts, reset recovery)
//   dut_b : PC_W=8,  RESET_PC=0xF8, ALLOW_UPPER=1 (PC wrap-around, LUI legal)
// Each instance has a 1-cycle instruction memory model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rv_fetch_seq;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_fetch_seq_if #(.PC_W(11)) bus_a ();
    rv_fetch_seq_if #(.PC_W(8))  bus_b ();

`ifdef RV_FETCH_PERF_EN
    logic [31:0] perf_issued_a, perf_redirects_a;
    logic [31:0] perf_issued_b, perf_redirects_b;
`endif

    rv_fetch_seq #(
        .PC_W        (11),
        .RESET_PC    (11'h000),
        .ALLOW_UPPER (1'b0)
    ) dut_a (
        .clk            (clk),
        .rst            (rst_a),
        .bus            (bus_a)
`ifdef RV_FETCH_PERF_EN
        ,
        .perf_issued    (perf_issued_a),
        .perf_redirects (perf_redirects_a)
`endif
    );

    rv_fetch_seq #(
        .PC_W        (8),
        .RESET_PC    (8'hF8),
        .ALLOW_UPPER (1'b1)
    ) dut_b (
        .clk            (clk),
        .rst            (rst_b),
        .bus            (bus_b)
`ifdef RV_FETCH_PERF_EN
        ,
        .perf_issued    (perf_issued_b),
        .perf_redirects (perf_redirects_b)
`endif
    );

    // ---------------- 1-cycle memory models ----------------
    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:63];

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            bus_a.imem_rvalid <= 1'b0;
            bus_a.imem_rdata  <= 32'h0;
        end else begin
            bus_a.imem_rvalid <= bus_a.imem_req && !bus_a.imem_rvalid;
            bus_a.imem_rdata  <= mem_a[bus_a.imem_addr[10:2]];
        end
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            bus_b.imem_rvalid <= 1'b0;
            bus_b.imem_rdata  <= 32'h0;
        end else begin
            bus_b.imem_rvalid <= bus_b.imem_req && !bus_b.imem_rvalid;
            bus_b.imem_rdata  <= mem_b[bus_b.imem_addr[7:2]];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until instr_valid is seen (bounded).
    task automatic wait_valid_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_a.instr_valid !== 1'b1 && n < 20);
    endtask

    task automatic wait_valid_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_b.instr_valid !== 1'b1 && n < 20);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_imem_req"},    32'(bus_a.imem_req),    32'h0);
        check({tag, "_instr_valid"}, 32'(bus_a.instr_valid), 32'h0);
        check({tag, "_instr"},       bus_a.instr,            32'h0);
        check({tag, "_instr_pc"},    32'(bus_a.instr_pc),    32'h0);
        check({tag, "_link_pc"},     32'(bus_a.link_pc),     32'h0);
        check({tag, "_halt"},        32'(bus_a.halt),        32'h0);
        check({tag, "_halt_cause"},  32'(bus_a.halt_cause),  32'h0);
        check({tag, "_halt_pc"},     32'(bus_a.halt_pc),     32'h0);
`ifdef RV_FETCH_PERF_EN
        check({tag, "_perf_issued"},    perf_issued_a,    32'h0);
        check({tag, "_perf_redirects"}, perf_redirects_a, 32'h0);
`endif
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic saw_valid;

        for (int i = 0; i < 512; i++) mem_a[i] = 32'h0000_0013;   // addi x0,x0,0
        for (int i = 0; i < 64; i++)  mem_b[i] = 32'h0000_0013;
        mem_a[2]  = 32'h0011_2023;   // 0x008: sw x1,0(x2)
        mem_a[16] = 32'h0010_0093;   // 0x040: addi x1,x0,1
        mem_a[17] = 32'h0000_006F;   // 0x044: jal x0,0
        mem_b[63] = 32'h0000_10B7;   // 0xFC : lui x1,1 (legal with ALLOW_UPPER)

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.instr_ready     = 1'b1;
        bus_a.redirect_valid  = 1'b0;
        bus_a.redirect_target = 11'h0;
        bus_b.instr_ready     = 1'b1;
        bus_b.redirect_valid  = 1'b0;
        bus_b.redirect_target = 8'h0;

        repeat (2) @(negedge clk);
        check_reset_a("rst0");

        rst_a = 1'b0;
        #1;
        check("start_req",  32'(bus_a.imem_req),  32'h1);
        check("start_addr", 32'(bus_a.imem_addr), 32'h0);

        // --- sequential fetch: 0, 4, 8 every 3 cycles ---
        wait_valid_a(n);
        check("lat0", n, 2);
        check("i0_pc",    32'(bus_a.instr_pc), 32'h000);
        check("i0_link",  32'(bus_a.link_pc),  32'h004);
        check("i0_instr", bus_a.instr,         32'h0000_0013);

        wait_valid_a(n);
        check("gap1", n, 3);
        check("i1_pc",   32'(bus_a.instr_pc), 32'h004);
        check("i1_link", 32'(bus_a.link_pc),  32'h008);

        wait_valid_a(n);
        check("gap2", n, 3);
        check("i2_pc",    32'(bus_a.instr_pc), 32'h008);
        check("i2_link",  32'(bus_a.link_pc),  32'h00C);
        check("i2_instr", bus_a.instr,         32'h0011_2023);

        // --- aligned redirect to 0x40 on accept of 0x8 ---
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 11'h040;
        @(negedge clk);
        bus_a.redirect_valid  = 1'b0;
        check("redir_req",   32'(bus_a.imem_req),    32'h1);
        check("redir_addr",  32'(bus_a.imem_addr),   32'h040);
        check("redir_valid", 32'(bus_a.instr_valid), 32'h0);

        wait_valid_a(n);
        check("lat_redir", n, 2);
        check("i3_pc",    32'(bus_a.instr_pc), 32'h040);
        check("i3_link",  32'(bus_a.link_pc),  32'h044);
        check("i3_instr", bus_a.instr,         32'h0010_0093);

        // --- stall for 5 cycles; redirect seen outside accept is ignored ---
        bus_a.instr_ready     = 1'b0;
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 11'h080;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus_a.instr_valid), 32'h1);
            check("stall_req",   32'(bus_a.imem_req),    32'h0);
            check("stall_pc",    32'(bus_a.instr_pc),    32'h040);
            check("stall_instr", bus_a.instr,            32'h0010_0093);
        end
        bus_a.redirect_valid = 1'b0;
        bus_a.instr_ready    = 1'b1;
        @(negedge clk);
        check("post_stall_req",  32'(bus_a.imem_req),  32'h1);
        check("post_stall_addr", 32'(bus_a.imem_addr), 32'h044);

        wait_valid_a(n);
        check("lat_post_stall", n, 2);
        check("i4_pc",    32'(bus_a.instr_pc), 32'h044);
        check("i4_instr", bus_a.instr,         32'h0000_006F);
`ifdef RV_FETCH_PERF_EN
        check("perf_issued_4",    perf_issued_a,    32'd4);
        check("perf_redirects_1", perf_redirects_a, 32'd1);
`endif

        // --- misaligned redirect target 0x42 -> HALT cause 2 ---
        bus_a.redirect_valid  = 1'b1;
        bus_a.redirect_target = 11'h042;
        @(negedge clk);
        bus_a.redirect_valid  = 1'b0;
        check("mis_halt",  32'(bus_a.halt),        32'h1);
        check("mis_cause", 32'(bus_a.halt_cause),  32'(HC_MISALIGN));
        check("mis_pc",    32'(bus_a.halt_pc),     32'h044);
        check("mis_valid", 32'(bus_a.instr_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mis_hold_req",  32'(bus_a.imem_req),   32'h0);
            check("mis_hold_halt", 32'(bus_a.halt),       32'h1);
            check("mis_hold_cause", 32'(bus_a.halt_cause), 32'(HC_MISALIGN));
        end
`ifdef RV_FETCH_PERF_EN
        check("perf_issued_5",      perf_issued_a,    32'd5);
        check("perf_redirects_hold", perf_redirects_a, 32'd1);
`endif

        // --- async reset out of HALT, then illegal opcode at 0xC ---
        mem_a[3] = 32'h0000_0000;
        #2;
        rst_a = 1'b1;
        #1;
        check_reset_a("rst1");
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("restart_req",  32'(bus_a.imem_req),  32'h1);
        check("restart_addr", 32'(bus_a.imem_addr), 32'h0);

        wait_valid_a(n);
        check("r_lat0", n, 2);
        check("r_i0_pc", 32'(bus_a.instr_pc), 32'h000);
        wait_valid_a(n);
        check("r_gap1", n, 3);
        check("r_i1_pc", 32'(bus_a.instr_pc), 32'h004);
        wait_valid_a(n);
        check("r_gap2", n, 3);
        check("r_i2_pc", 32'(bus_a.instr_pc), 32'h008);

        saw_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus_a.instr_valid === 1'b1) saw_valid = 1'b1;
        end while (bus_a.halt !== 1'b1 && n < 10);
        check("ill_lat",      n, 3);
        check("ill_no_issue", 32'(saw_valid),        32'h0);
        check("ill_halt",     32'(bus_a.halt),       32'h1);
        check("ill_cause",    32'(bus_a.halt_cause), 32'(HC_ILLEGAL));
        check("ill_pc",       32'(bus_a.halt_pc),    32'h00C);
        check("ill_instr_pc", 32'(bus_a.instr_pc),   32'h008);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ill_hold_req",   32'(bus_a.imem_req),    32'h0);
            check("ill_hold_valid", 32'(bus_a.instr_valid), 32'h0);
        end

        // --- PC_W=8 wrap-around from 0xF8 ---
        check("b_rst_req", 32'(bus_b.imem_req), 32'h0);
        rst_b = 1'b0;
        #1;
        check("b_start_addr", 32'(bus_b.imem_addr), 32'h0F8);
        wait_valid_b(n);
        check("b_lat0",   n, 2);
        check("b0_pc",    32'(bus_b.instr_pc), 32'h0F8);
        check("b0_link",  32'(bus_b.link_pc),  32'h0FC);
        wait_valid_b(n);
        check("b_gap1",   n, 3);
        check("b1_pc",    32'(bus_b.instr_pc), 32'h0FC);
        check("b1_link",  32'(bus_b.link_pc),  32'h000);
        check("b1_instr", bus_b.instr,         32'h0000_10B7);
        wait_valid_b(n);
        check("b_gap2",   n, 3);
        check("b2_pc",    32'(bus_b.instr_pc), 32'h000);
        check("b2_link",  32'(bus_b.link_pc),  32'h004);
        check("b_no_halt", 32'(bus_b.halt),    32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_fetch_seq.md
Name: rv_fetch_seq

Overview:
Parametrised fetch/sequencing unit that replaces the free-running PC register of the single-cycle core. It generates requests to instruction memory through a req/rvalid handshake and presents each fetched instruction with its PC and link address. It accepts branch/JAL/JALR redirects from execute and halts on an illegal opcode or a misaligned target. This lets the core run with multi-cycle ROMs and gives it a real HALT flag.

Parameters:
PC_W, 11, PC/address width in bits; all PC arithmetic is modulo 2^PC_W.
RESET_PC, 0, PC value loaded on reset (must be word-aligned).
ALLOW_UPPER, 0, when 1, LUI (0110111) and AUIPC (0010111) are legal opcodes.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request; held high until imem_rvalid
imem_addr  out  PC_W  word-aligned fetch address (equals pc)
imem_rvalid  in  1  read data valid; sampled only while imem_req=1
imem_rdata  in  32  instruction word
instr_valid  out  1  instr/instr_pc/link_pc are valid
instr  out  32  registered instruction
instr_pc  out  PC_W  PC of instr
link_pc  out  PC_W  instr_pc+4 (JAL/JALR write-back value)
instr_ready  in  1  core consumes instr this cycle
redirect_valid  in  1  taken branch/jump; sampled only with instr_valid&instr_ready
redirect_target  in  PC_W  next PC when redirect_valid
halt  out  1  sticky halt flag
halt_cause  out  2  0 none, 1 illegal opcode, 2 misaligned redirect
halt_pc  out  PC_W  PC of the offending instruction

Behaviour:
- Reset (async, rst=1): state=REQ, pc=RESET_PC, imem_req=0 during reset; instr_valid=0, instr=0, instr_pc=0, link_pc=0, halt=0, halt_cause=0, halt_pc=0.
- States: REQ, ISSUE, HALT.
- REQ: imem_req=1, imem_addr=pc. When imem_rvalid=1:
  - If the opcode rdata[6:0] is legal (R, I, S, L, B, JAL, JALR, plus LUI/AUIPC if ALLOW_UPPER): register instr=rdata, instr_pc=pc, link_pc=pc+4; go to ISSUE. instr_valid rises on the next cycle.
  - If the opcode is illegal: go to HALT with halt_cause=1 and halt_pc=pc. The word is never presented.
- ISSUE: imem_req=0 and instr_valid=1; outputs are held stable until instr_ready=1. On accept:
  - redirect_valid=0: pc<=pc+4.
  - redirect_valid=1 with target[1:0]==0: pc<=redirect_target.
  - redirect_valid=1 with target[1:0]!=0: go to HALT with halt_cause=2 and halt_pc=instr_pc.
  - Otherwise, after accept, go to REQ.
- HALT: imem_req=0, instr_valid=0, halt=1; halt_cause and halt_pc are frozen. HALT is left only by rst.
- Throughput: with 1-cycle memory (rvalid the cycle after req rises) and instr_ready tied high, one instruction is issued every 3 cycles.
- Wrap-around: pc+4 wraps silently from 2^PC_W-4 to 0. link_pc wraps the same way.
- redirect_valid/redirect_target are ignored outside the accept cycle.
- imem_rvalid is ignored unless state=REQ.
- Reset mid-fetch: an outstanding request is abandoned. A late rvalid after reset is accepted as the response to the new RESET_PC request, so memory must also be reset by rst.
- halt stays 0 until entering HALT; halt_cause=0 while not halted.

Optional Feature:
- RV_FETCH_PERF_EN defined: adds output ports perf_issued (32) and perf_redirects (32), both reset to 0.
  - perf_issued increments on every accept.
  - perf_redirects increments on every accept with redirect_valid=1 and an aligned target.
  - Both counters wrap modulo 2^32 and freeze in HALT.
- Not defined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package rv_pkg: opcode localparams (OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), fetch state encoding (ST_REQ, ST_ISSUE, ST_HALT), and halt-cause codes (HC_NONE, HC_ILLEGAL, HC_MISALIGN).
- One combinational sub-module, rv_opcode_legal (opcode[6:0], allow_upper -> legal), which the control unit can reuse.

Test Plan:
- Reset then 1-cycle memory returning 0x00000013 (addi) at each address, instr_ready=1 -> instr_valid pulses every 3 cycles with instr_pc 0, 4, 8; link_pc 4, 8, 12.
- Accept at instr_pc=8 with redirect_valid=1, target=0x40 -> next imem_addr=0x40, instr_pc=0x40; perf_redirects=1 if enabled.
- instr_ready held 0 for 5 cycles -> instr, instr_pc and instr_valid are stable; no imem_req; pc advances only after ready.
- rdata=0x00000000 at pc=0xC -> HALT: halt=1, halt_cause=1, halt_pc=0xC, instr_valid never asserted; imem_req stays 0 thereafter.
- Redirect target=0x42 -> halt_cause=2, halt_pc=accepted instr_pc; assert rst -> all outputs return to reset values and fetch restarts at RESET_PC.
- PC_W=8: fetch sequentially from 0xF8 -> instr_pc goes 0xF8, 0xFC, 0x00; link_pc of 0xFC is 0x00.
